// File: rtl/fir_sequencer.sv
// FIR run sequencer: walks outputs n and taps k, issues coefficient/sample
// reads, drives the MAC enable/clear pipeline and the output-memory write,
// and reports busy/done back to ctrl_registers.
module fir_sequencer #(
  parameter int MEM_LAT = 1,  // read address to data at MAC inputs, >= 1
  parameter int MAC_LAT = 2   // last mac_en of a sample to valid accumulator, >= 1
) (
  input  logic        clk_b,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [5:0]  Ile_wsp,
  input  logic [13:0] Ile_probek,
  output logic        Pracuje,
  output logic        DONE,
  output logic        rd_en,
  output logic [5:0]  coef_addr,
  output logic [13:0] sample_addr,
  output logic        mac_en,
  output logic        mac_clr,
  output logic        out_we,
  output logic [13:0] out_addr
);

  // Control protocol: Start is a level; only a 0->1 transition seen while
  // IDLE or FIN launches a run. Pracuje is high for the whole run, DONE is
  // sticky from the end of a run until the next accepted launch or reset.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  // Cycles spent between the last read of a sample and its write strobe.
  localparam int          WAIT_CYC  = MEM_LAT + MAC_LAT - 1;
  localparam logic [15:0] WAIT_LOAD = 16'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

  logic [2:0]  state;
  logic        start_q;
  logic [5:0]  wsp_q;
  logic [13:0] probek_q;
  logic [13:0] n;
  logic [5:0]  k;
  logic [15:0] wcnt;
  logic        start_edge;
  logic        last_term;
  logic        last_sample;
  logic [MEM_LAT-1:0] en_sr;
  logic [MEM_LAT-1:0] clr_sr;

  // Launch qualification and end-of-loop conditions.
  // The tap loop ends at k = min(Ile_wsp, n+1) - 1: whichever bound k hits
  // first, since k counts up from 0 and never passes n.
  always_comb begin
    start_edge  = Start & ~start_q & ((state == S_IDLE) || (state == S_FIN));
    last_term   = (({9'd0, k} + 15'd1) == {9'd0, wsp_q}) || ({8'd0, k} == n);
    last_sample = (({1'b0, n} + 15'd1) == {1'b0, probek_q});
  end

  // Sampled copy of Start; resets high so a Start held through reset is not an edge.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b1;
    else        start_q <= Start;
  end

  // Main sequencing FSM with the n/k counters and latched run lengths.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wsp_q    <= 6'd0;
      probek_q <= 14'd0;
      n        <= 14'd0;
      k        <= 6'd0;
      wcnt     <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (start_edge) begin
            wsp_q    <= Ile_wsp;
            probek_q <= Ile_probek;
            n        <= 14'd0;
            k        <= 6'd0;
            if ((Ile_wsp != 6'd0) && (Ile_probek != 14'd0)) state <= S_ISSUE;
            else                                            state <= S_FIN;
          end
        end
        S_ISSUE: begin
          if (last_term) begin
            if (WAIT_CYC == 0) begin
              state <= S_WRITE;
            end else begin
              state <= S_WAIT;
              wcnt  <= WAIT_LOAD;
            end
          end else begin
            k <= k + 6'd1;
          end
        end
        S_WAIT: begin
          if (wcnt == 16'd0) state <= S_WRITE;
          else               wcnt  <= wcnt - 16'd1;
        end
        S_WRITE: begin
          if (last_sample) begin
            state <= S_FIN;
          end else begin
            n     <= n + 14'd1;
            k     <= 6'd0;
            state <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // State-decoded outputs; addresses are forced to 0 outside their strobe.
  always_comb begin
    Pracuje     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_WRITE);
    DONE        = (state == S_FIN);
    rd_en       = (state == S_ISSUE);
    coef_addr   = 6'd0;
    sample_addr = 14'd0;
    out_we      = (state == S_WRITE);
    out_addr    = 14'd0;
    if (state == S_ISSUE) begin
      coef_addr   = k;
      sample_addr = n - {8'd0, k};
    end
    if (state == S_WRITE) out_addr = n;
  end

  // Delay rd_en and the first-tap flag by the memory latency to line up with read data.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      en_sr  <= '0;
      clr_sr <= '0;
    end else begin
      en_sr[0]  <= rd_en;
      clr_sr[0] <= rd_en & (k == 6'd0);
      for (int i = 1; i < MEM_LAT; i++) begin
        en_sr[i]  <= en_sr[i-1];
        clr_sr[i] <= clr_sr[i-1];
      end
    end
  end

  assign mac_en  = en_sr[MEM_LAT-1];
  assign mac_clr = clr_sr[MEM_LAT-1];

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: three instances (MEM_LAT/MAC_LAT = 1/2, 3/1, 1/1),
// a trace model that lays out every expected output cycle of a run from the
// tap/latency arithmetic, a per-cycle compare process, and directed checks
// with hand-computed literals.
module tb_fir_sequencer;

  typedef struct packed {
    logic        pracuje;
    logic        done;
    logic        rd_en;
    logic [5:0]  coef;
    logic [13:0] sample;
    logic        mac_en;
    logic        mac_clr;
    logic        out_we;
    logic [13:0] out_addr;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk_b = 1'b0;
  always #5 clk_b = ~clk_b;

  logic        rst_s    [3];
  logic        start_s  [3];
  logic [5:0]  wsp_s    [3];
  logic [13:0] probek_s [3];
  logic        prac_s   [3];
  logic        done_s   [3];
  logic        rd_s     [3];
  logic [5:0]  coef_s   [3];
  logic [13:0] samp_s   [3];
  logic        macen_s  [3];
  logic        macclr_s [3];
  logic        we_s     [3];
  logic [13:0] oaddr_s  [3];

  fir_sequencer #(.MEM_LAT(1), .MAC_LAT(2)) u_a (
    .clk_b(clk_b), .rst_n(rst_s[0]), .Start(start_s[0]), .Ile_wsp(wsp_s[0]),
    .Ile_probek(probek_s[0]), .Pracuje(prac_s[0]), .DONE(done_s[0]), .rd_en(rd_s[0]),
    .coef_addr(coef_s[0]), .sample_addr(samp_s[0]), .mac_en(macen_s[0]),
    .mac_clr(macclr_s[0]), .out_we(we_s[0]), .out_addr(oaddr_s[0]));

  fir_sequencer #(.MEM_LAT(3), .MAC_LAT(1)) u_b (
    .clk_b(clk_b), .rst_n(rst_s[1]), .Start(start_s[1]), .Ile_wsp(wsp_s[1]),
    .Ile_probek(probek_s[1]), .Pracuje(prac_s[1]), .DONE(done_s[1]), .rd_en(rd_s[1]),
    .coef_addr(coef_s[1]), .sample_addr(samp_s[1]), .mac_en(macen_s[1]),
    .mac_clr(macclr_s[1]), .out_we(we_s[1]), .out_addr(oaddr_s[1]));

  fir_sequencer #(.MEM_LAT(1), .MAC_LAT(1)) u_c (
    .clk_b(clk_b), .rst_n(rst_s[2]), .Start(start_s[2]), .Ile_wsp(wsp_s[2]),
    .Ile_probek(probek_s[2]), .Pracuje(prac_s[2]), .DONE(done_s[2]), .rd_en(rd_s[2]),
    .coef_addr(coef_s[2]), .sample_addr(samp_s[2]), .mac_en(macen_s[2]),
    .mac_clr(macclr_s[2]), .out_we(we_s[2]), .out_addr(oaddr_s[2]));

  function automatic int ml(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int cl(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // ---------------- scoreboard state ----------------
  int   vectors = 0;
  int   fails   = 0;
  vec_t exp_q [3][$];
  logic mdone [3];
  logic sprev [3];

  int rd_cnt[3], we_cnt[3], prac_cnt[3], mac_cnt[3], clr_cnt[3], run_cyc[3];
  int last_oaddr[3], max_coef[3], max_samp[3];
  int pair_q[$];
  int we_cyc_q[$];
  int we_addr_q[$];

  // Lay out the full expected trace of one run: per output n, T reads, then
  // MEM_LAT+MAC_LAT-1 idle busy cycles, then the write; mac_en/clr trail reads by MEM_LAT.
  task automatic build(input int i, input int w, input int p);
    vec_t seg [0:127];
    int   t, len, m, c;
    m = ml(i);
    c = cl(i);
    for (int n = 0; n < p; n++) begin
      t   = (w < n + 1) ? w : n + 1;
      len = t + m + c;
      for (int j = 0; j < len; j++) begin
        seg[j] = '0;
        seg[j].pracuje = 1'b1;
      end
      for (int kk = 0; kk < t; kk++) begin
        seg[kk].rd_en        = 1'b1;
        seg[kk].coef         = 6'(kk);
        seg[kk].sample       = 14'(n - kk);
        seg[kk + m].mac_en   = 1'b1;
        seg[kk + m].mac_clr  = (kk == 0);
      end
      seg[len-1].out_we   = 1'b1;
      seg[len-1].out_addr = 14'(n);
      for (int j = 0; j < len; j++) exp_q[i].push_back(seg[j]);
    end
  endtask

  // Model advance: front of each queue is the cycle now in progress.
  always @(posedge clk_b) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_s[i]) begin
        exp_q[i].delete();
        mdone[i] = 1'b0;
        sprev[i] = 1'b1;
      end else begin
        logic busy;
        busy = (exp_q[i].size() != 0);
        if (busy) void'(exp_q[i].pop_front());
        if (busy && exp_q[i].size() == 0) mdone[i] = 1'b1;
        if (!busy && start_s[i] && !sprev[i]) begin
          if (wsp_s[i] != 6'd0 && probek_s[i] != 14'd0) begin
            mdone[i] = 1'b0;
            build(i, int'(wsp_s[i]), int'(probek_s[i]));
          end else begin
            mdone[i] = 1'b1;
          end
        end
        sprev[i] = start_s[i];
      end
    end
  end

  function automatic vec_t act_vec(input int i);
    vec_t v;
    v.pracuje  = prac_s[i];
    v.done     = done_s[i];
    v.rd_en    = rd_s[i];
    v.coef     = coef_s[i];
    v.sample   = samp_s[i];
    v.mac_en   = macen_s[i];
    v.mac_clr  = macclr_s[i];
    v.out_we   = we_s[i];
    v.out_addr = oaddr_s[i];
    return v;
  endfunction

  // Per-cycle compare against the model, plus event monitors for the directed checks.
  always @(negedge clk_b) begin
    for (int i = 0; i < 3; i++) begin
      vec_t a, e;
      a = act_vec(i);
      if (!rst_s[i])                 e = '0;
      else if (exp_q[i].size() != 0) e = exp_q[i][0];
      else begin
        e = '0;
        e.done = mdone[i];
      end
      vectors++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_cmp inst%0d t=%0t actual=%h required=%h", i, $time, a, e);
      end
      if (a.rd_en) begin
        rd_cnt[i]++;
        if (int'(a.coef) > max_coef[i]) max_coef[i] = int'(a.coef);
        if (int'(a.sample) > max_samp[i]) max_samp[i] = int'(a.sample);
        if (i == 0) pair_q.push_back(int'(a.coef) * 65536 + int'(a.sample));
      end
      if (a.mac_en)  mac_cnt[i]++;
      if (a.mac_clr) clr_cnt[i]++;
      if (a.out_we) begin
        we_cnt[i]++;
        last_oaddr[i] = int'(a.out_addr);
        if (i == 0) begin
          we_cyc_q.push_back(run_cyc[i]);
          we_addr_q.push_back(int'(a.out_addr));
        end
      end
      if (a.pracuje) begin
        prac_cnt[i]++;
        run_cyc[i]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_b);
    #2;
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic clr_mon(input int i);
    rd_cnt[i] = 0; we_cnt[i] = 0; prac_cnt[i] = 0; mac_cnt[i] = 0; clr_cnt[i] = 0;
    run_cyc[i] = 0; last_oaddr[i] = -1; max_coef[i] = -1; max_samp[i] = -1;
    if (i == 0) begin
      pair_q.delete();
      we_cyc_q.delete();
      we_addr_q.delete();
    end
  endtask

  task automatic start_low(input int i);
    start_s[i] = 1'b0;
    step();
  endtask

  task automatic launch(input int i, input int w, input int p);
    clr_mon(i);
    wsp_s[i]    = 6'(w);
    probek_s[i] = 14'(p);
    start_s[i]  = 1'b1;
    step();
  endtask

  task automatic wait_done(input int i, input int budget, input string name);
    for (int j = 0; j < budget && !done_s[i]; j++) step();
    chk(name, int'(done_s[i]), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pexp [6];
    int cexp [5];
    pexp = '{0, 1, 65536, 2, 65537, 131072};
    cexp = '{3, 8, 13, 18, 23};
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b0; start_s[i] = 1'b0; wsp_s[i] = 6'd0; probek_s[i] = 14'd0;
      clr_mon(i);
    end
    start_s[0] = 1'b1;  // held high through reset: must not launch
    steps(3);
    chk("reset_outputs_zero", int'(act_vec(0) == '0), 1);
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b1;
    steps(5);
    chk("start_held_no_launch_busy", prac_cnt[0], 0);
    chk("start_held_no_launch_done", int'(done_s[0]), 0);

    // long-running instances in the background
    start_low(1);
    start_low(2);
    launch(1, 63, 70);
    launch(2, 1, 16383);

    // 1: W=4, P=3
    start_low(0);
    launch(0, 4, 3);
    wait_done(0, 100, "t1_done");
    chk("t1_rd_count", rd_cnt[0], 6);
    chk("t1_we_count", we_cnt[0], 3);
    chk("t1_busy_cycles", prac_cnt[0], 15);
    for (int j = 0; j < 6; j++)
      chk($sformatf("t1_pair%0d", j), (j < pair_q.size()) ? pair_q[j] : -1, pexp[j]);
    for (int j = 0; j < 3; j++)
      chk($sformatf("t1_out_addr%0d", j), (j < we_addr_q.size()) ? we_addr_q[j] : -1, j);

    // 2: W=2, P=5 -> periods 4,5,5,5,5
    start_low(0);
    launch(0, 2, 5);
    wait_done(0, 100, "t2_done");
    for (int j = 0; j < 5; j++)
      chk($sformatf("t2_we_cycle%0d", j), (j < we_cyc_q.size()) ? we_cyc_q[j] : -1, cexp[j]);
    chk("t2_mac_en_count", mac_cnt[0], 9);
    chk("t2_mac_clr_count", clr_cnt[0], 5);

    // 3: zero counts
    start_low(0);
    launch(0, 0, 5);
    chk("t3_wsp0_done_next", int'(done_s[0]), 1);
    steps(4);
    start_low(0);
    launch(0, 7, 0);
    chk("t3_probek0_done_next", int'(done_s[0]), 1);
    steps(4);
    chk("t3_no_busy", prac_cnt[0], 0);
    chk("t3_no_rd", rd_cnt[0], 0);
    chk("t3_no_we", we_cnt[0], 0);

    // 4: edges and input changes during a run are ignored
    start_low(0);
    launch(0, 3, 4);
    chk("t4_done_cleared", int'(done_s[0]), 0);
    steps(2);
    start_s[0] = 1'b0;
    step();
    start_s[0] = 1'b1;
    wsp_s[0] = 6'd10;
    probek_s[0] = 14'd2;
    step();
    wait_done(0, 100, "t4_done");
    chk("t4_rd_count", rd_cnt[0], 9);
    chk("t4_we_count", we_cnt[0], 4);
    steps(3);
    chk("t4_no_relaunch", prac_cnt[0], 21);
    start_low(0);
    launch(0, 2, 3);
    wait_done(0, 100, "t4_rerun_done");
    chk("t4_rerun_rd", rd_cnt[0], 5);
    chk("t4_rerun_we", we_cnt[0], 3);

    // 5: reset in WAIT with Start held high
    start_low(0);
    launch(0, 4, 3);
    for (int j = 0; j < 50 && !(prac_s[0] && !rd_s[0] && !we_s[0]); j++) step();
    chk("t5_reached_wait", int'(prac_s[0] && !rd_s[0] && !we_s[0]), 1);
    rst_s[0] = 1'b0;
    #1;
    chk("t5_async_zero", int'(act_vec(0) == '0), 1);
    steps(3);
    rst_s[0] = 1'b1;
    clr_mon(0);
    steps(30);
    chk("t5_no_we_after", we_cnt[0], 0);
    chk("t5_no_busy_after", prac_cnt[0], 0);
    chk("t5_no_done_after", int'(done_s[0]), 0);
    start_low(0);
    launch(0, 4, 3);
    wait_done(0, 100, "t5_rerun_done");
    chk("t5_rerun_we", we_cnt[0], 3);

    // 6: long/boundary runs
    wait_done(1, 6000, "t6b_done");
    chk("t6b_we_count", we_cnt[1], 70);
    chk("t6b_rd_count", rd_cnt[1], 2457);
    chk("t6b_last_addr", last_oaddr[1], 69);
    chk("t6b_max_coef", max_coef[1], 62);
    chk("t6b_max_sample", max_samp[1], 69);
    wait_done(2, 60000, "t6c_done");
    chk("t6c_we_count", we_cnt[2], 16383);
    chk("t6c_rd_count", rd_cnt[2], 16383);
    chk("t6c_last_addr", last_oaddr[2], 16382);
    chk("t6c_max_sample", max_samp[2], 16382);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
